alu_op_sequencer: RTL and testbench

- Initiator side of the ALU interface: accepts operation requests over a valid/ready handshake and decodes ALUOp/Funct into the 4-bit ALUControl code.
- Drives A, B and ALUControl into the combinational ALU, captures Result/Zero one cycle later, and returns them over a second valid/ready handshake.
- Sits between the multi-cycle controller/datapath and the ALU instance.

---
 rtl/alu_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//   Initiator side of the ALU interface. Accepts an operation request over a
//   valid/ready handshake and decodes ALUOp/Funct into the 4-bit ALUControl
//   code. It then drives A, B and ALUControl into the combinational ALU,
//   captures Result/Zero one cycle later and returns them over a second
//   valid/ready handshake.
//
//   Each legal op takes three cycles:
//     IDLE (accept) -> EXEC (ALU settles) -> RESP (response offered)
//   Undecodable ops skip EXEC and are answered straight from IDLE with
//   Illegal=1 and a zero result.
//
// Optional build macro:
//   ALU_SEQ_CHECK_EN - adds an internal reference model that compares the
//                      ALU Result/Zero during EXEC and raises a sticky
//                      Mismatch flag. When undefined, Mismatch is tied to 0.
//
// Parameters:
//   WIDTH      - data width of operands and result
//   CNT_W      - width of the completed-operation counter
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   op_valid   in   request valid
//   op_ready   out  sequencer can accept a request
//   ALUOp      in   00=add, 01=sub, 10=use Funct, 11=reserved
//   Funct      in   R-type function field
//   SrcA       in   operand A
//   SrcB       in   operand B
//   A          out  to ALU A input
//   B          out  to ALU B input
//   ALUControl out  to ALU control input
//   Result     in   from ALU
//   Zero       in   from ALU
//   res_valid  out  response valid
//   res_ready  in   consumer accepts response
//   ResultOut  out  captured result
//   ZeroOut    out  captured zero flag
//   Illegal    out  response is for an undecodable op
//   OpCount    out  number of completed responses (wraps silently)
//   Mismatch   out  sticky ALU self-check flag
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       ALUOp,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] Result,
   input  logic             Zero,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] ResultOut,
   output logic             ZeroOut,
   output logic             Illegal,
   output logic [CNT_W-1:0] OpCount,
   output logic             Mismatch
);

   // ALU control encodings
   localparam logic [3:0] C_AND = 4'b0000;
   localparam logic [3:0] C_OR  = 4'b0001;
   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_SUB = 4'b0110;
   localparam logic [3:0] C_SLT = 4'b0111;

   // R-type function codes
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Decode ALUOp/Funct. Returns {illegal, code}; illegal ops carry the ADD
   // code as a harmless filler that is never written to ALUControl.
   function automatic logic [4:0] f_decode(input logic [1:0] alu_op,
                                           input logic [5:0] funct);
      logic [4:0] v_dec;
      v_dec = {1'b1, C_ADD};
      case (alu_op)
         2'b00: v_dec = {1'b0, C_ADD};
         2'b01: v_dec = {1'b0, C_SUB};
         2'b10: begin
            case (funct)
               F_ADD:   v_dec = {1'b0, C_ADD};
               F_SUB:   v_dec = {1'b0, C_SUB};
               F_AND:   v_dec = {1'b0, C_AND};
               F_OR:    v_dec = {1'b0, C_OR};
               F_SLT:   v_dec = {1'b0, C_SLT};
               default: v_dec = {1'b1, C_ADD};
            endcase
         end
         default: v_dec = {1'b1, C_ADD};
      endcase
      return v_dec;
   endfunction

   state_t           r_state;
   logic             r_op_ready;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_alu_ctrl;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;
   logic [CNT_W-1:0] r_count;

   logic [4:0]       w_dec;
   logic             w_dec_illegal;
   logic [3:0]       w_dec_code;
   logic             w_accept;
   logic             w_res_hs;

   // Request decode and handshake qualifiers
   always_comb begin
      w_dec         = f_decode(ALUOp, Funct);
      w_dec_illegal = w_dec[4];
      w_dec_code    = w_dec[3:0];
      w_accept      = op_valid & r_op_ready;
      w_res_hs      = r_res_valid & res_ready;
   end

   // Sequencer FSM with all interface outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op_ready  <= 1'b1;
         r_a         <= {WIDTH{1'b0}};
         r_b         <= {WIDTH{1'b0}};
         r_alu_ctrl  <= C_ADD;
         r_res_valid <= 1'b0;
         r_result    <= {WIDTH{1'b0}};
         r_zero      <= 1'b0;
         r_illegal   <= 1'b0;
         r_count     <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op_ready <= 1'b0;
                  if (w_dec_illegal) begin
                     // Answer immediately; operands and control stay put so
                     // the ALU inputs do not toggle for a rejected op.
                     r_result    <= {WIDTH{1'b0}};
                     r_zero      <= 1'b0;
                     r_illegal   <= 1'b1;
                     r_res_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end else begin
                     r_a        <= SrcA;
                     r_b        <= SrcB;
                     r_alu_ctrl <= w_dec_code;
                     r_state    <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               // ALU inputs were stable for the whole cycle; sample outputs.
               r_result    <= Result;
               r_zero      <= Zero;
               r_illegal   <= 1'b0;
               r_res_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               // Response registers are simply not written here, so they
               // hold while the consumer stalls.
               if (w_res_hs) begin
                  r_res_valid <= 1'b0;
                  r_op_ready  <= 1'b1;
                  r_count     <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_op_ready  <= 1'b1;
               r_res_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_CHECK_EN
   // Reference ALU: add, sub, and, or and signed set-less-than.
   function automatic logic [WIDTH-1:0] f_ref_alu(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [3:0]       ctrl);
      logic [WIDTH-1:0] v_res;
      v_res = {WIDTH{1'b0}};
      case (ctrl)
         C_ADD:   v_res = a + b;
         C_SUB:   v_res = a - b;
         C_AND:   v_res = a & b;
         C_OR:    v_res = a | b;
         C_SLT:   v_res = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                                    : {WIDTH{1'b0}};
         default: v_res = {WIDTH{1'b0}};
      endcase
      return v_res;
   endfunction

   logic             r_mismatch;
   logic [WIDTH-1:0] w_expected;
   logic             w_bad;

   // Expected ALU output and per-cycle discrepancy detection
   always_comb begin
      w_expected = f_ref_alu(r_a, r_b, r_alu_ctrl);
      if (r_state == S_EXEC) begin
         w_bad = (Result != w_expected) || (Zero != (Result == {WIDTH{1'b0}}));
      end else begin
         w_bad = 1'b0;
      end
   end

   // Sticky mismatch flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mismatch <= 1'b0;
      end else if (w_bad) begin
         r_mismatch <= 1'b1;
      end else begin
         r_mismatch <= r_mismatch;
      end
   end

   assign Mismatch = r_mismatch;
`else
   assign Mismatch = 1'b0;
`endif

   assign op_ready   = r_op_ready;
   assign A          = r_a;
   assign B          = r_b;
   assign ALUControl = r_alu_ctrl;
   assign res_valid  = r_res_valid;
   assign ResultOut  = r_result;
   assign ZeroOut    = r_zero;
   assign Illegal    = r_illegal;
   assign OpCount    = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer built with CNT_W=4 so the counter wrap
// is reachable quickly. A behavioural ALU is attached to A/B/ALUControl; it
// can be made faulty (Result+1) to exercise the Mismatch flag. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             op_valid;
   logic             op_ready;
   logic [1:0]       ALUOp;
   logic [5:0]       Funct;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] Result;
   logic             Zero;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] ResultOut;
   logic             ZeroOut;
   logic             Illegal;
   logic [CNT_W-1:0] OpCount;
   logic             Mismatch;

   logic             fault;
   logic [CNT_W-1:0] exp_count;
   logic             exp_mismatch;
   int               checks;
   int               errors;

   alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .ALUOp      (ALUOp),
      .Funct      (Funct),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .Result     (Result),
      .Zero       (Zero),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .ResultOut  (ResultOut),
      .ZeroOut    (ZeroOut),
      .Illegal    (Illegal),
      .OpCount    (OpCount),
      .Mismatch   (Mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU, optionally off by one
   always_comb begin
      logic [WIDTH-1:0] v_r;
      case (ALUControl)
         4'b0010: v_r = A + B;
         4'b0110: v_r = A - B;
         4'b0000: v_r = A & B;
         4'b0001: v_r = A | B;
         4'b0111: v_r = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
         default: v_r = 32'd0;
      endcase
      Result = v_r + (fault ? 32'd1 : 32'd0);
      Zero   = (Result == 32'd0);
   end

   // Present a request at a falling edge and wait for res_valid.
   // lat = number of falling edges from the accept cycle to res_valid.
   task automatic run_op(input logic [1:0] aop, input logic [5:0] fn,
                         input logic [31:0] sa, input logic [31:0] sb,
                         output int lat);
      ALUOp    = aop;
      Funct    = fn;
      SrcA     = sa;
      SrcB     = sb;
      op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      if (!res_valid) lat = 99;
   endtask

   // Complete the response handshake (one cycle)
   task automatic finish_resp();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_count = exp_count + 4'd1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_count    = 4'd0;
      exp_mismatch = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++; if (A !== 32'd0 || B !== 32'd0) begin errors++; $display("FAIL reset_ab: got A=%0d B=%0d expected 0 0", A, B); end
      checks++; if (ALUControl !== 4'b0010) begin errors++; $display("FAIL reset_ctrl: got %b expected 0010", ALUControl); end
      checks++; if (ResultOut !== 32'd0 || ZeroOut !== 1'b0 || Illegal !== 1'b0) begin errors++; $display("FAIL reset_resp: got res=%0d z=%b ill=%b expected 0 0 0", ResultOut, ZeroOut, Illegal); end
      checks++; if (OpCount !== 4'd0 || Mismatch !== 1'b0) begin errors++; $display("FAIL reset_cnt_mm: got cnt=%0d mm=%b expected 0 0", OpCount, Mismatch); end
   endtask

   task automatic test_add();
      int lat;
      run_op(2'b00, 6'b000000, 32'd10, 32'd5, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
      checks++; if (ALUControl !== 4'b0010) begin errors++; $display("FAIL add_ctrl: got %b expected 0010", ALUControl); end
      checks++; if (ResultOut !== 32'd15 || ZeroOut !== 1'b0 || Illegal !== 1'b0) begin errors++; $display("FAIL add_result: got res=%0d z=%b ill=%b expected 15 0 0", ResultOut, ZeroOut, Illegal); end
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL add_op_ready_resp: got %b expected 0", op_ready); end
      finish_resp();
      checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL add_handshake: got rv=%b rdy=%b expected 0 1", res_valid, op_ready); end
      checks++; if (OpCount !== 4'd1) begin errors++; $display("FAIL add_count: got %0d expected 1", OpCount); end
   endtask

   task automatic test_funct();
      // funct, a, b, ctrl, result, zero
      logic [5:0]  t_fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101010};
      logic [31:0] t_a   [6] = '{32'd3, 32'd10, 32'd10, 32'd10, 32'd10, 32'd5};
      logic [31:0] t_b   [6] = '{32'd4, 32'd5,  32'd5,  32'd5,  32'd5,  32'd10};
      logic [3:0]  t_c   [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0111};
      logic [31:0] t_r   [6] = '{32'd7, 32'd5,  32'd0,  32'd15, 32'd0,  32'd1};
      logic        t_z   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(2'b10, t_fn[i], t_a[i], t_b[i], lat);
         checks++; if (ALUControl !== t_c[i] || lat !== 2) begin errors++; $display("FAIL funct_ctrl[%0d]: got ctrl=%b lat=%0d expected %b 2", i, ALUControl, lat, t_c[i]); end
         checks++; if (ResultOut !== t_r[i] || ZeroOut !== t_z[i]) begin errors++; $display("FAIL funct_result[%0d]: got res=%0d z=%b expected %0d %b", i, ResultOut, ZeroOut, t_r[i], t_z[i]); end
         finish_resp();
      end
      checks++; if (OpCount !== exp_count) begin errors++; $display("FAIL funct_count: got %0d expected %0d", OpCount, exp_count); end
   endtask

   task automatic test_sub();
      int lat;
      run_op(2'b01, 6'b000000, 32'd7, 32'd7, lat);
      checks++; if (ALUControl !== 4'b0110) begin errors++; $display("FAIL sub_ctrl: got %b expected 0110", ALUControl); end
      checks++; if (ResultOut !== 32'd0 || ZeroOut !== 1'b1) begin errors++; $display("FAIL sub_result: got res=%0d z=%b expected 0 1", ResultOut, ZeroOut); end
      finish_resp();
   endtask

   task automatic test_illegal();
      int lat;
      run_op(2'b00, 6'b000000, 32'd20, 32'd22, lat);
      checks++; if (ResultOut !== 32'd42) begin errors++; $display("FAIL illegal_pre: got %0d expected 42", ResultOut); end
      finish_resp();
      run_op(2'b10, 6'b111111, 32'd99, 32'd98, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_funct_latency: got %0d expected 1", lat); end
      checks++; if (Illegal !== 1'b1 || ResultOut !== 32'd0 || ZeroOut !== 1'b0) begin errors++; $display("FAIL illegal_funct_resp: got ill=%b res=%0d z=%b expected 1 0 0", Illegal, ResultOut, ZeroOut); end
      checks++; if (A !== 32'd20 || B !== 32'd22 || ALUControl !== 4'b0010) begin errors++; $display("FAIL illegal_funct_hold: got A=%0d B=%0d ctrl=%b expected 20 22 0010", A, B, ALUControl); end
      finish_resp();
      run_op(2'b11, 6'b100000, 32'd1, 32'd2, lat);
      checks++; if (lat !== 1 || Illegal !== 1'b1 || ResultOut !== 32'd0) begin errors++; $display("FAIL illegal_aluop: got lat=%0d ill=%b res=%0d expected 1 1 0", lat, Illegal, ResultOut); end
      checks++; if (A !== 32'd20 || B !== 32'd22 || ALUControl !== 4'b0010) begin errors++; $display("FAIL illegal_aluop_hold: got A=%0d B=%0d ctrl=%b expected 20 22 0010", A, B, ALUControl); end
      finish_resp();
      checks++; if (OpCount !== exp_count) begin errors++; $display("FAIL illegal_count: got %0d expected %0d", OpCount, exp_count); end
      // A following legal op clears Illegal
      run_op(2'b00, 6'b000000, 32'd1, 32'd1, lat);
      checks++; if (Illegal !== 1'b0 || ResultOut !== 32'd2) begin errors++; $display("FAIL illegal_clear: got ill=%b res=%0d expected 0 2", Illegal, ResultOut); end
      finish_resp();
   endtask

   task automatic test_back_to_back_hold();
      int lat;
      run_op(2'b00, 6'b000000, 32'd100, 32'd23, lat);
      // Stall the consumer and push a competing request
      ALUOp    = 2'b01;
      SrcA     = 32'd55;
      SrcB     = 32'd44;
      op_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (res_valid !== 1'b1 || ResultOut !== 32'd123 || op_ready !== 1'b0 || A !== 32'd100) begin errors++; $display("FAIL hold[%0d]: got rv=%b res=%0d rdy=%b A=%0d expected 1 123 0 100", i, res_valid, ResultOut, op_ready, A); end
      end
      op_valid = 1'b0;
      finish_resp();
      checks++; if (OpCount !== exp_count) begin errors++; $display("FAIL hold_count: got %0d expected %0d", OpCount, exp_count); end
      // res_ready while idle must not count
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++; if (OpCount !== exp_count || res_valid !== 1'b0) begin errors++; $display("FAIL idle_res_ready: got cnt=%0d rv=%b expected %0d 0", OpCount, res_valid, exp_count); end
   endtask

   task automatic test_reset_mid_exec();
      ALUOp    = 2'b00;
      SrcA     = 32'd8;
      SrcB     = 32'd9;
      op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      res_ready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      res_ready = 1'b0;
      exp_count = 4'd0;
      exp_mismatch = 1'b0;
      checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1 || OpCount !== 4'd0) begin errors++; $display("FAIL reset_exec: got rv=%b rdy=%b cnt=%0d expected 0 1 0", res_valid, op_ready, OpCount); end
      checks++; if (A !== 32'd0 || ALUControl !== 4'b0010) begin errors++; $display("FAIL reset_exec_regs: got A=%0d ctrl=%b expected 0 0010", A, ALUControl); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_exec_quiet: got rv=%b expected 0", res_valid); end
   endtask

   task automatic test_wrap();
      int lat;
      for (int i = 0; i < 15; i++) begin
         run_op(2'b00, 6'b000000, i, 32'd1, lat);
         finish_resp();
      end
      checks++; if (OpCount !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d expected 15", OpCount); end
      run_op(2'b00, 6'b000000, 32'd2, 32'd2, lat);
      finish_resp();
      checks++; if (OpCount !== 4'd0) begin errors++; $display("FAIL wrap: got %0d expected 0", OpCount); end
   endtask

   task automatic test_mismatch();
      int lat;
      checks++; if (Mismatch !== 1'b0) begin errors++; $display("FAIL mm_clean: got %b expected 0", Mismatch); end
      fault = 1'b1;
      run_op(2'b00, 6'b000000, 32'd10, 32'd5, lat);
      fault = 1'b0;
`ifdef ALU_SEQ_CHECK_EN
      exp_mismatch = 1'b1;
`else
      exp_mismatch = 1'b0;
`endif
      checks++; if (ResultOut !== 32'd16) begin errors++; $display("FAIL mm_result: got %0d expected 16", ResultOut); end
      checks++; if (Mismatch !== exp_mismatch) begin errors++; $display("FAIL mm_set: got %b expected %b", Mismatch, exp_mismatch); end
      finish_resp();
      run_op(2'b00, 6'b000000, 32'd1, 32'd1, lat);
      checks++; if (Mismatch !== exp_mismatch || ResultOut !== 32'd2) begin errors++; $display("FAIL mm_sticky: got mm=%b res=%0d expected %b 2", Mismatch, ResultOut, exp_mismatch); end
      finish_resp();
      apply_reset();
      checks++; if (Mismatch !== 1'b0) begin errors++; $display("FAIL mm_reset: got %b expected 0", Mismatch); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      fault = 1'b0;
      reset = 1'b1;
      op_valid = 1'b0;
      res_ready = 1'b0;
      ALUOp = 2'b00;
      Funct = 6'b000000;
      SrcA = 32'd0;
      SrcB = 32'd0;
      exp_count = 4'd0;
      exp_mismatch = 1'b0;
      @(negedge clk);
      test_reset();
      test_add();
      test_funct();
      test_sub();
      test_illegal();
      test_back_to_back_hold();
      test_reset_mid_exec();
      test_wrap();
      test_mismatch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
